fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Tracks destination registers of in-flight instructions in EX, MEM and WB.
- Generates the 2-bit operand-forwarding selects that drive the two EX-stage operand mux4 instances (ALU A and B).
- Detects load-use hazards: stalls IF/ID and injects a bubble.
- Honours branch flush from EX and a global memory freeze.

Parameters:
- REG_ADDR_W, 5, register index width
- NUM_REGS, 32, architectural register count (x0 hard-wired zero)

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- freeze  input  1  global pipeline hold (data-memory wait); all internal slots hold
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REG_ADDR_W  ID source 1
- id_rs2  input  REG_ADDR_W  ID source 2
- id_rs1_used  input  1  instruction reads rs1
- id_rs2_used  input  1  instruction reads rs2
- id_rd  input  REG_ADDR_W  ID destination
- id_regwrite  input  1  ID writes rd
- id_memread  input  1  ID is a load
- ex_flush  input  1  branch/jump taken, resolved in EX this cycle
- stall  output  1  hold PC and IF/ID register
- bubble  output  1  ID/EX register loads NOP
- fwd_a_sel  output  2  select for operand-A mux4
- fwd_b_sel  output  2  select for operand-B mux4

Behaviour:
- Select encoding: 2'b00 register-file value; 2'b01 WB write-back data; 2'b10 MEM ALU result; 2'b11 never driven (d3 tied off by integrator).
- Internal slots, each with a valid bit:
  - EX: rs1, rs2, rs1_used, rs2_used, rd, regwrite, memread
  - MEM: rd, regwrite, memread
  - WB: rd, regwrite
- Reset (async, rst_n low): all valid bits 0. Outputs then read stall=0, bubble=0, fwd_a_sel=fwd_b_sel=00.
- Slot advance on each rising edge when freeze=0:
  - WB<=MEM and MEM<=EX.
  - EX loads the ID fields (valid=id_valid) unless bubble=1, in which case EX.valid<=0.
  - freeze=1: every slot holds and stall/bubble are forced 0.
- Forwarding (combinational from slots; zero cycles after slot update):
  - fwd_a_sel=10 if MEM.valid & MEM.regwrite & !MEM.memread & MEM.rd!=0 & MEM.rd==EX.rs1 & EX.rs1_used.
  - Else 01 if the same test holds on WB (no memread term).
  - Else 00.
  - fwd_b_sel: identical, using rs2.
  - MEM has priority over WB on a simultaneous match.
  - EX.valid=0 forces 00.
- Load-use hazard: hz = id_valid & EX.valid & EX.memread & EX.rd!=0 & ((id_rs1_used & id_rs1==EX.rd) | (id_rs2_used & id_rs2==EX.rd)).
  - stall=hz & !ex_flush & !freeze.
  - bubble=(hz | ex_flush) & !freeze.
  - Exactly one stall cycle per load-use pair. The following cycle the load sits in MEM and EX holds the bubble, so no re-stall. The dependent instruction then reaches EX with the load in WB and receives select 01.
- A load in MEM never forwards via 10; the hazard logic guarantees it is not needed.
- Flush overrides stall: the squashed ID instruction never enters EX, and the EX branch still advances normally.
- rd==0 never forwards and never stalls.
- rst_n asserted mid-stall: immediate clear; no pending state survives.

Optional Feature:
- HAZ_PERF_CNT_EN defined: adds output stall_cnt [31:0].
  - Increments on every clock with stall=1; wraps at 2^32.
  - Reset to 0 by rst_n.
  - Holds while freeze=1.
- HAZ_PERF_CNT_EN undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Slot struct typedef.
  - REG_ADDR_W.
- One sub-module, fwd_sel_gen: purely combinational; maps (source reg, used, MEM slot, WB slot) to fwd_sel_t. Instantiated twice, for A and B.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 back-to-back -> sub in EX gives fwd_a_sel=10, fwd_b_sel=00; no stall.
- add x5 then nop then or x7,x4,x5 -> or in EX gives fwd_b_sel=01.
- lw x8,0(x1) then add x9,x8,x8 -> exactly one cycle stall=1 and bubble=1; add in EX next-but-one gives fwd_a_sel=fwd_b_sel=01.
- Same lw/add pair with ex_flush=1 on the hazard cycle -> stall=0, bubble=1; EX.valid=0 next cycle.
- add x0,x1,x2 then sub x3,x0,x0 -> selects stay 00; x5 written by both MEM and WB slots -> 10 wins.
- freeze=1 for 3 cycles mid load-use -> stall=0, slots unchanged; hazard resolves after release. rst_n pulse mid-stream -> all outputs 0 asynchronously (stall_cnt=0 with HAZ_PERF_CNT_EN).

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding / hazard controller: mux select encoding,
// pipeline slot records and the register-index width.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // d3 of the operand mux4 is tied off by the integrator, so 2'b11 is never produced
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      rs1_used;
    logic      rs2_used;
    reg_addr_t rd;
    logic      regwrite;
    logic      memread;
  } ex_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      regwrite;
    logic      memread;
  } mem_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      regwrite;
  } wb_slot_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel_gen.sv
// Combinational forwarding-select generator for one EX-stage operand.
// MEM beats WB; loads sitting in MEM never forward and x0 never forwards.
module fwd_sel_gen
  import hazard_pkg::*;
(
  input  logic      ex_valid,
  input  reg_addr_t src_reg,
  input  logic      src_used,
  input  mem_slot_t mem_slot,
  input  wb_slot_t  wb_slot,
  output fwd_sel_t  sel
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = ex_valid & src_used & mem_slot.valid & mem_slot.regwrite &
              !mem_slot.memread & (mem_slot.rd != '0) & (mem_slot.rd == src_reg);
    wb_hit  = ex_valid & src_used & wb_slot.valid & wb_slot.regwrite &
              (wb_slot.rd != '0) & (wb_slot.rd == src_reg);
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding and load-use hazard controller tracking EX/MEM/WB.
// Optional macro HAZ_PERF_CNT_EN adds a 32-bit stall_cnt performance counter.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic                  bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  import hazard_pkg::*;

  // Slot records are sized by the package, so the parameters must agree with it
  if (REG_ADDR_W != hazard_pkg::REG_ADDR_W || NUM_REGS != (1 << REG_ADDR_W)) begin : g_bad_cfg
    $error("fwd_hazard_ctrl: REG_ADDR_W/NUM_REGS disagree with hazard_pkg");
  end

  ex_slot_t  ex_q;
  mem_slot_t mem_q;
  wb_slot_t  wb_q;

  logic     hz;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  // A load in EX whose rd is needed by ID cannot be forwarded in time
  always_comb begin
    hz = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
         ((id_rs1_used & (id_rs1 == ex_q.rd)) | (id_rs2_used & (id_rs2 == ex_q.rd)));
    stall  = hz & !ex_flush & !freeze;
    bubble = (hz | ex_flush) & !freeze;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      wb_q.valid     <= mem_q.valid;
      wb_q.rd        <= mem_q.rd;
      wb_q.regwrite  <= mem_q.regwrite;
      mem_q.valid    <= ex_q.valid;
      mem_q.rd       <= ex_q.rd;
      mem_q.regwrite <= ex_q.regwrite;
      mem_q.memread  <= ex_q.memread;
      if (bubble) begin
        ex_q <= '0;
      end else begin
        ex_q.valid    <= id_valid;
        ex_q.rs1      <= id_rs1;
        ex_q.rs2      <= id_rs2;
        ex_q.rs1_used <= id_rs1_used;
        ex_q.rs2_used <= id_rs2_used;
        ex_q.rd       <= id_rd;
        ex_q.regwrite <= id_regwrite;
        ex_q.memread  <= id_memread;
      end
    end
  end

  fwd_sel_gen u_fwd_a (
    .ex_valid (ex_q.valid),
    .src_reg  (ex_q.rs1),
    .src_used (ex_q.rs1_used),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (sel_a)
  );

  fwd_sel_gen u_fwd_b (
    .ex_valid (ex_q.valid),
    .src_reg  (ex_q.rs2),
    .src_used (ex_q.rs2_used),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (sel_b)
  );

  assign fwd_a_sel = sel_a;
  assign fwd_b_sel = sel_b;

`ifdef HAZ_PERF_CNT_EN
  // stall is already masked by freeze, so the counter naturally holds then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, hand-written reset case and
// randomized traffic checked against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  localparam int AW = 5;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
  } instr_t;

  typedef struct {
    instr_t     id;
    logic       flush;
    logic       frz;
    logic       exp_stall;
    logic       exp_bubble;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          freeze = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0;
  logic [AW-1:0] id_rs2 = '0;
  logic          id_rs1_used = 1'b0;
  logic          id_rs2_used = 1'b0;
  logic [AW-1:0] id_rd = '0;
  logic          id_regwrite = 1'b0;
  logic          id_memread = 1'b0;
  logic          ex_flush = 1'b0;
  logic          stall;
  logic          bubble;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int total = 0;
  int bad = 0;

  // Model state: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t      pipe [3];
  int unsigned model_cnt;
  instr_t      cur_id;
  vec_t        vecs [$];

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .ex_flush    (ex_flush),
    .stall       (stall),
    .bubble      (bubble),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  function automatic instr_t ins(input int v, input int rs1, input int rs2, input int u1,
                                 input int u2, input int rd, input int rw, input int mr);
    instr_t r;
    r.v = 1'(v); r.rs1 = AW'(rs1); r.rs2 = AW'(rs2); r.u1 = 1'(u1);
    r.u2 = 1'(u2); r.rd = AW'(rd); r.rw = 1'(rw); r.mr = 1'(mr);
    return r;
  endfunction

  // Youngest older producer wins; a load still in MEM cannot supply its data
  function automatic logic [1:0] modelFwd(input logic [AW-1:0] src, input logic used);
    if (!pipe[0].v || !used) return 2'd0;
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src &&
          !(k == 1 && pipe[k].mr))
        return (k == 1) ? 2'd2 : 2'd1;
    end
    return 2'd0;
  endfunction

  function automatic logic modelHazard();
    instr_t e;
    e = pipe[0];
    if (!cur_id.v || !e.v || !e.mr || e.rd == 0) return 1'b0;
    return (cur_id.u1 && cur_id.rs1 == e.rd) || (cur_id.u2 && cur_id.rs2 == e.rd);
  endfunction

  function automatic logic modelStall();
    return modelHazard() && !ex_flush && !freeze;
  endfunction

  function automatic logic modelBubble();
    return (modelHazard() || ex_flush) && !freeze;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    model_cnt = 0;
  endtask

  task automatic modelAdvance();
    logic st, bu;
    st = modelStall();
    bu = modelBubble();
    if (!freeze) begin
      if (st) model_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = bu ? instr_t'('0) : cur_id;
    end
  endtask

  task automatic applyStimulus(input instr_t id, input logic flush, input logic frz);
    cur_id      = id;
    id_valid    = id.v;
    id_rs1      = id.rs1;
    id_rs2      = id.rs2;
    id_rs1_used = id.u1;
    id_rs2_used = id.u2;
    id_rd       = id.rd;
    id_regwrite = id.rw;
    id_memread  = id.mr;
    ex_flush    = flush;
    freeze      = frz;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic es, input logic eb,
                          input logic [1:0] ea, input logic [1:0] ebs);
    checkOutput({name, ".stall"}, 32'(stall), 32'(es));
    checkOutput({name, ".bubble"}, 32'(bubble), 32'(eb));
    checkOutput({name, ".fwd_a"}, 32'(fwd_a_sel), 32'(ea));
    checkOutput({name, ".fwd_b"}, 32'(fwd_b_sel), 32'(ebs));
`ifdef HAZ_PERF_CNT_EN
    checkOutput({name, ".stall_cnt"}, stall_cnt, model_cnt);
`endif
  endtask

  // Called just after a falling edge: drive, settle, compare, then clock once
  task automatic doCycle(input string name, input bit fromTable, input vec_t v);
    logic es, eb;
    logic [1:0] ea, ebs;
    applyStimulus(v.id, v.flush, v.frz);
    #1;
    if (fromTable) begin
      es = v.exp_stall; eb = v.exp_bubble; ea = v.exp_a; ebs = v.exp_b;
    end else begin
      es = modelStall(); eb = modelBubble();
      ea = modelFwd(pipe[0].rs1, pipe[0].u1);
      ebs = modelFwd(pipe[0].rs2, pipe[0].u2);
    end
    checkAll(name, es, eb, ea, ebs);
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  task automatic addVec(input instr_t id, input logic fl, input logic fz, input logic st,
                        input logic bu, input logic [1:0] a, input logic [1:0] b);
    vec_t v;
    v.id = id; v.flush = fl; v.frz = fz; v.exp_stall = st;
    v.exp_bubble = bu; v.exp_a = a; v.exp_b = b;
    vecs.push_back(v);
  endtask

  initial begin
    instr_t nop, add5, sub6, or7, lw8, add9, xor10, add0, sub3, add5b, or55, lw0, add00;
    vec_t   v;
    nop   = '0;
    add5  = ins(1, 1, 2, 1, 1, 5, 1, 0);
    sub6  = ins(1, 5, 3, 1, 1, 6, 1, 0);
    or7   = ins(1, 4, 5, 1, 1, 7, 1, 0);
    lw8   = ins(1, 1, 0, 1, 0, 8, 1, 1);
    add9  = ins(1, 8, 8, 1, 1, 9, 1, 0);
    xor10 = ins(1, 9, 8, 1, 1, 10, 1, 0);
    add0  = ins(1, 1, 2, 1, 1, 0, 1, 0);
    sub3  = ins(1, 0, 0, 1, 1, 3, 1, 0);
    add5b = ins(1, 3, 4, 1, 1, 5, 1, 0);
    or55  = ins(1, 5, 5, 1, 1, 7, 1, 0);
    lw0   = ins(1, 1, 0, 1, 0, 0, 1, 1);
    add00 = ins(1, 0, 0, 1, 1, 9, 1, 0);

    // back-to-back ALU dependency, MEM forward on A
    addVec(add5, 0, 0, 0, 0, 0, 0);
    addVec(sub6, 0, 0, 0, 0, 0, 0);
    addVec(nop,  0, 0, 0, 0, 2, 0);
    addVec(nop,  0, 0, 0, 0, 0, 0);
    // one-gap dependency, WB forward on B
    addVec(add5, 0, 0, 0, 0, 0, 0);
    addVec(nop,  0, 0, 0, 0, 0, 0);
    addVec(or7,  0, 0, 0, 0, 0, 0);
    addVec(nop,  0, 0, 0, 0, 0, 1);
    // load-use: single stall, then WB forward on both
    addVec(lw8,  0, 0, 0, 0, 0, 0);
    addVec(add9, 0, 0, 1, 1, 0, 0);
    addVec(add9, 0, 0, 0, 0, 0, 0);
    addVec(nop,  0, 0, 0, 0, 1, 1);
    addVec(nop,  0, 0, 0, 0, 0, 0);
    // load-use with flush on the hazard cycle
    addVec(lw8,   0, 0, 0, 0, 0, 0);
    addVec(add9,  1, 0, 0, 1, 0, 0);
    addVec(xor10, 0, 0, 0, 0, 0, 0);
    addVec(nop,   0, 0, 0, 0, 0, 1);
    // x0 never forwards
    addVec(add0, 0, 0, 0, 0, 0, 0);
    addVec(sub3, 0, 0, 0, 0, 0, 0);
    addVec(nop,  0, 0, 0, 0, 0, 0);
    // x5 produced in both MEM and WB, MEM wins
    addVec(add5,  0, 0, 0, 0, 0, 0);
    addVec(add5b, 0, 0, 0, 0, 0, 0);
    addVec(or55,  0, 0, 0, 0, 0, 0);
    addVec(nop,   0, 0, 0, 0, 2, 2);
    // load to x0 never stalls
    addVec(lw0,   0, 0, 0, 0, 0, 0);
    addVec(add00, 0, 0, 0, 0, 0, 0);
    addVec(nop,   0, 0, 0, 0, 0, 0);
    addVec(nop,   0, 0, 0, 0, 0, 0);
    // freeze for three cycles in the middle of a load-use pair
    addVec(lw8,  0, 0, 0, 0, 0, 0);
    addVec(add9, 0, 1, 0, 0, 0, 0);
    addVec(add9, 0, 1, 0, 0, 0, 0);
    addVec(add9, 0, 1, 0, 0, 0, 0);
    addVec(add9, 0, 0, 1, 1, 0, 0);
    addVec(add9, 0, 0, 0, 0, 0, 0);
    addVec(nop,  0, 0, 0, 0, 1, 1);

    modelReset();
    applyStimulus(nop, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    checkAll("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      doCycle($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end

    // asynchronous reset while a load-use stall is being raised
    v.flush = 0; v.frz = 0;
    v.id = lw8;  doCycle("rst_lw", 1'b0, v);
    applyStimulus(add9, 0, 0);
    #1;
    checkOutput("rst_pre.stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("rst_async", 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v.id = add9; doCycle("rst_after", 1'b1, '{add9, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});

    // randomized traffic over a small register window to provoke matches
    for (int i = 0; i < 800; i++) begin
      v.id.v   = 1'($urandom_range(0, 9) != 0);
      v.id.rs1 = AW'($urandom_range(0, 4));
      v.id.rs2 = AW'($urandom_range(0, 4));
      v.id.u1  = 1'($urandom_range(0, 3) != 0);
      v.id.u2  = 1'($urandom_range(0, 2) != 0);
      v.id.rd  = AW'($urandom_range(0, 4));
      v.id.rw  = 1'($urandom_range(0, 4) != 0);
      v.id.mr  = v.id.rw && ($urandom_range(0, 2) == 0);
      v.flush  = 1'($urandom_range(0, 9) == 0);
      v.frz    = 1'($urandom_range(0, 7) == 0);
      doCycle($sformatf("rnd%0d", i), 1'b0, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
